// File: rtl/window_buffer.sv
// rtl/window_buffer.sv - K x K causal sliding-window generator for streamed video
//
// Ports:
//   clk, rst                  single clock, asynchronous active-high reset
//   pixel_in, hsync, vsync, de input video (pixel sampled when de=1)
//   hsync_dl, vsync_dl, de_dl  control delayed by two cycles
//   window_out                tap (r,c) at [(r*K+c)*DATA_W +: DATA_W], r/c=0 oldest
//   x_out, y_out              coordinates of the newest tap (K-1,K-1)
//   edge_out                  {top, 0, left, 0}
//   err_overflow              sticky "line longer than MAX_WIDTH", cleared on vsync rise

module window_buffer #(
    parameter int DATA_W    = 8,
    parameter int K         = 3,
    parameter int MAX_WIDTH = 2100,
    parameter int BORDER    = 0,
    parameter int XW        = 12,
    parameter int YW        = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        pixel_in,
    input  logic                     hsync,
    input  logic                     vsync,
    input  logic                     de,
    output logic                     hsync_dl,
    output logic                     vsync_dl,
    output logic                     de_dl,
    output logic [K*K*DATA_W-1:0]    window_out,
    output logic [XW-1:0]            x_out,
    output logic [YW-1:0]            y_out,
    output logic [3:0]               edge_out,
    output logic                     err_overflow
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int IW = $clog2(K);
    localparam logic [XW-1:0] X_LAST = XW'(MAX_WIDTH - 1);
    localparam logic [XW-1:0] X_EDGE = XW'(K - 1);
    localparam logic [YW-1:0] Y_EDGE = YW'(K - 1);

    // Stage 0: counters
    logic          armed;
    logic [XW-1:0] x;
    logic          x_full;
    logic [YW-1:0] y;

    // Stage 1: registered inputs and memory read
    logic              de_d1, hs_d1, vs_d1, vsr_d1, ovf_d1;
    logic [DATA_W-1:0] pix_d1;
    logic [XW-1:0]     x_d1;
    logic [YW-1:0]     y_d1;

    logic [DATA_W-1:0] line_mem [K-1][MAX_WIDTH];
    logic [DATA_W-1:0] rd_q     [K-1];
    logic [DATA_W-1:0] wr_data  [K-1];
    logic [DATA_W-1:0] new_col  [K];
    logic [DATA_W-1:0] win      [K][K];

    // After reset the remainder of an interrupted line is ignored, so the
    // first whole line seen becomes row 0 and no stale line memory leaks out.
    logic de_act, vs_rise, de_fall, at_last, ovf_px, mem_we;
    assign de_act  = de & armed;
    assign vs_rise = vsync & ~vs_d1;
    assign de_fall = de_d1 & ~de_act;
    assign at_last = (x == X_LAST);
    assign ovf_px  = de_act & x_full;
    assign mem_we  = de_d1 & ~ovf_d1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed  <= 1'b0;
            x      <= '0;
            x_full <= 1'b0;
            y      <= '0;
        end else begin
            armed <= armed | ~de;
            if (de_act) begin
                if (!at_last) x <= x + 1'b1;
                if (at_last)  x_full <= 1'b1;
            end else begin
                x      <= '0;
                x_full <= 1'b0;
            end
            if (vs_rise)      y <= '0;
            else if (de_fall) y <= y + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_d1  <= 1'b0;
            hs_d1  <= 1'b0;
            vs_d1  <= 1'b0;
            vsr_d1 <= 1'b0;
            ovf_d1 <= 1'b0;
            pix_d1 <= '0;
            x_d1   <= '0;
            y_d1   <= '0;
        end else begin
            de_d1  <= de_act;
            hs_d1  <= hsync;
            vs_d1  <= vsync;
            vsr_d1 <= vs_rise;
            ovf_d1 <= ovf_px;
            pix_d1 <= pixel_in;
            x_d1   <= x;
            y_d1   <= y;
        end
    end

    // Memory j receives what memory j-1 returned for this address on the
    // previous cycle, so each memory is one line older than the one before.
    always_comb begin
        wr_data[0] = pix_d1;
        for (int j = 1; j < K - 1; j++) wr_data[j] = rd_q[j-1];
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < K - 1; j++) begin
            if (mem_we) line_mem[j][x_d1[AW-1:0]] <= wr_data[j];
            rd_q[j] <= line_mem[j][x[AW-1:0]];
        end
    end

    // Stage 2: window shift register, newest row from the live pixel
    always_comb begin
        new_col[K-1] = pix_d1;
        for (int r = 0; r < K - 1; r++) new_col[r] = rd_q[K-2-r];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_dl     <= 1'b0;
            vsync_dl     <= 1'b0;
            de_dl        <= 1'b0;
            err_overflow <= 1'b0;
            x_out        <= '0;
            y_out        <= '0;
            edge_out     <= '0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    win[r][c] <= '0;
        end else begin
            hsync_dl     <= hs_d1;
            vsync_dl     <= vs_d1;
            de_dl        <= de_d1;
            err_overflow <= (err_overflow & ~vsr_d1) | ovf_d1;
            if (de_d1) begin
                x_out    <= x_d1;
                y_out    <= y_d1;
                edge_out <= {(y_d1 < Y_EDGE), 1'b0, (x_d1 < X_EDGE), 1'b0};
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
                    win[r][K-1] <= new_col[r];
                end
            end
        end
    end

    // Padding mux on the registered taps. In replicate mode an out-of-image
    // tap is redirected to the nearest in-image row/column inside the window.
    always_comb begin
        int          xi, yi;
        logic        row_ok, col_ok;
        logic [IW-1:0] rs, cs;
        window_out = '0;
        xi     = int'(x_out);
        yi     = int'(y_out);
        row_ok = 1'b0;
        col_ok = 1'b0;
        rs     = '0;
        cs     = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                row_ok = (yi >= K - 1 - r);
                col_ok = (xi >= K - 1 - c);
                rs = row_ok ? IW'(r) : IW'(K - 1 - yi);
                cs = col_ok ? IW'(c) : IW'(K - 1 - xi);
                if (BORDER == 1)
                    window_out[(r*K+c)*DATA_W +: DATA_W] = win[rs][cs];
                else if (row_ok && col_ok)
                    window_out[(r*K+c)*DATA_W +: DATA_W] = win[r][c];
            end
        end
    end

endmodule
